// File: rtl/pipelined_shifter_pkg.sv
// Shared definitions for the pipelined shifter.
//   - Mode codes carried on in_mode (2 bits).
//   - shamt_w(): shift-amount width for a given operand width.
//   - is_rank_end(): true when a pipeline register rank follows stage k.
//     Stages are split evenly across the ranks; the leftover stages go to
//     the first rank, so rank 0 is never shorter than the others.
package pipelined_shifter_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction

  function automatic bit is_rank_end(input int k, input int stages, input int ranks);
    int base;
    int rem;
    base = stages / ranks;
    rem  = stages % ranks;
    return ((k + 1) >= (base + rem)) && (((k + 1 - rem) % base) == 0);
  endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Handshake bundle for the pipelined shifter.
//   in_valid/in_ready   : operand side handshake
//   in_data/in_shamt/in_mode : operand, shift amount, mode code
//   out_valid/out_ready : result side handshake
//   out_data            : shifted result
// Modports: master = producer/consumer around the unit, slave = the unit.
interface pipelined_shifter_if
  import pipelined_shifter_pkg::*;
#(
  parameter int WIDTH = 32
);
  localparam int SHAMT_W = shamt_w(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipelined_shifter_shift_stage.sv
// shift_stage: one combinational mux stage of the shifter.
//   data_i : operand entering the stage
//   en_i   : shift-amount bit K; when low the operand passes unchanged
//   mode_i : mode code (SLL/SRL/SRA/ROR)
//   data_o : operand shifted by 2^K when en_i is high
// Macro SHIFTER_ROTATE_EN: when defined, mode 11 rotates right; otherwise
// no rotate logic is built and mode 11 falls into the SRL path.
module shift_stage
  import pipelined_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] data_o
);
  localparam int DIST = 1 << K;

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (mode_i)
        MODE_SLL: data_o = data_i << DIST;
        MODE_SRA: data_o = $signed(data_i) >>> DIST;
`ifdef SHIFTER_ROTATE_EN
        MODE_ROR: data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
`endif
        default:  data_o = data_i >> DIST;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: SLL/SRL/SRA (optional ROR) on a WIDTH-bit operand through
// log2(WIDTH) mux stages with RANKS register ranks in between.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset, clears every rank immediately
//   bus   : pipelined_shifter_if slave modport (in_* operand side, out_* result side)
// Parameters: WIDTH (power of 2, 8..64), RANKS (1..log2(WIDTH)).
// Macro SHIFTER_ROTATE_EN enables mode 11 as rotate right (see shift_stage).
// All ranks advance together on adv = !out_valid | out_ready; bubbles are kept.
module pipelined_shifter
  import pipelined_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RANKS = 2
) (
  input logic                clock,
  input logic                reset,
  pipelined_shifter_if.slave bus
);
  localparam int SHAMT_W = shamt_w(WIDTH);

  logic adv;
  logic out_valid;

  assign adv          = !out_valid || bus.out_ready;
  assign bus.in_ready = adv && !reset;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_st
    logic [WIDTH-1:0]   src_data;
    logic [SHAMT_W-1:0] src_shamt;
    logic [1:0]         src_mode;
    logic               src_valid;
    logic [WIDTH-1:0]   res_data;
    logic [WIDTH-1:0]   nxt_data;
    logic [SHAMT_W-1:0] nxt_shamt;
    logic [1:0]         nxt_mode;
    logic               nxt_valid;

    if (k == 0) begin : g_head
      assign src_data  = bus.in_data;
      assign src_shamt = bus.in_shamt;
      assign src_mode  = bus.in_mode;
      assign src_valid = bus.in_valid;
    end else begin : g_link
      assign src_data  = g_st[k-1].nxt_data;
      assign src_shamt = g_st[k-1].nxt_shamt;
      assign src_mode  = g_st[k-1].nxt_mode;
      assign src_valid = g_st[k-1].nxt_valid;
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .data_i (src_data),
      .en_i   (src_shamt[k]),
      .mode_i (src_mode),
      .data_o (res_data)
    );

    if (is_rank_end(k, SHAMT_W, RANKS)) begin : g_rank
      logic [WIDTH-1:0]   data_d,  data_q;
      logic [SHAMT_W-1:0] shamt_d, shamt_q;
      logic [1:0]         mode_d,  mode_q;
      logic               valid_d, valid_q;

      always_comb begin
        data_d  = data_q;
        shamt_d = shamt_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        if (adv) begin
          data_d  = res_data;
          shamt_d = src_shamt;
          mode_d  = src_mode;
          valid_d = src_valid;
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          data_q  <= '0;
          shamt_q <= '0;
          mode_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          data_q  <= data_d;
          shamt_q <= shamt_d;
          mode_q  <= mode_d;
          valid_q <= valid_d;
        end
      end

      assign nxt_data  = data_q;
      assign nxt_shamt = shamt_q;
      assign nxt_mode  = mode_q;
      assign nxt_valid = valid_q;
    end else begin : g_wire
      assign nxt_data  = res_data;
      assign nxt_shamt = src_shamt;
      assign nxt_mode  = src_mode;
      assign nxt_valid = src_valid;
    end
  end

  // The last stage always closes a rank, so the outputs are pure flops.
  assign out_valid     = g_st[SHAMT_W-1].nxt_valid;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = g_st[SHAMT_W-1].nxt_data;

  // shamt/mode are dead after the final stage; synthesis drops those flops.
  logic unused_tail;
  assign unused_tail = ^{g_st[SHAMT_W-1].nxt_shamt, g_st[SHAMT_W-1].nxt_mode};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter: three instances (8/1, 32/2, 64/6).
module tb_pipelined_shifter;
  import pipelined_shifter_pkg::*;

  localparam int RANKS8  = 1;
  localparam int RANKS32 = 2;
  localparam int RANKS64 = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  pipelined_shifter_if #(.WIDTH(8))  if8();
  pipelined_shifter_if #(.WIDTH(32)) if32();
  pipelined_shifter_if #(.WIDTH(64)) if64();

  pipelined_shifter #(.WIDTH(8),  .RANKS(RANKS8))  u_dut8  (.clock(clock), .reset(reset), .bus(if8));
  pipelined_shifter #(.WIDTH(32), .RANKS(RANKS32)) u_dut32 (.clock(clock), .reset(reset), .bus(if32));
  pipelined_shifter #(.WIDTH(64), .RANKS(RANKS64)) u_dut64 (.clock(clock), .reset(reset), .bus(if64));

  function automatic logic [63:0] model(input int w, input logic [63:0] a, input int sh, input logic [1:0] m);
    logic [63:0] mask, x, sx, r;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    x    = a & mask;
    sx   = x[w-1] ? (x | ~mask) : x;
    case (m)
      MODE_SLL: r = x << sh;
      MODE_SRA: r = $signed(sx) >>> sh;
`ifdef SHIFTER_ROTATE_EN
      MODE_ROR: r = (x >> sh) | (x << (w - sh));
`endif
      default:  r = x >> sh;
    endcase
    return r & mask;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [63:0] a, input int sh, input logic [1:0] m);
    case (sel)
      8: begin
        if8.in_valid = v; if8.in_data = a[7:0]; if8.in_shamt = sh[2:0];
        if8.in_mode = m; if8.out_ready = 1'b1;
      end
      32: begin
        if32.in_valid = v; if32.in_data = a[31:0]; if32.in_shamt = sh[4:0];
        if32.in_mode = m; if32.out_ready = 1'b1;
      end
      default: begin
        if64.in_valid = v; if64.in_data = a; if64.in_shamt = sh[5:0];
        if64.in_mode = m; if64.out_ready = 1'b1;
      end
    endcase
  endtask

  task automatic peek(input int sel, output logic v, output logic [63:0] d);
    case (sel)
      8:       begin v = if8.out_valid;  d = {56'd0, if8.out_data};  end
      32:      begin v = if32.out_valid; d = {32'd0, if32.out_data}; end
      default: begin v = if64.out_valid; d = if64.out_data;          end
    endcase
  endtask

  // One operation into an idle pipe; returns the result and the number of
  // rising edges from the transfer edge (inclusive) until out_valid, or -1.
  task automatic do_op(input int sel, input logic [63:0] a, input int sh, input logic [1:0] m,
                       output logic [63:0] res, output int lat);
    logic        v;
    logic [63:0] d;
    @(negedge clock);
    drive(sel, 1'b1, a, sh, m);
    @(posedge clock);
    lat = -1;
    res = '0;
    for (int i = 1; i <= 12 && lat < 0; i++) begin
      @(negedge clock);
      if (i == 1) drive(sel, 1'b0, 64'd0, 0, MODE_SLL);
      peek(sel, v, d);
      if (v === 1'b1) begin
        lat = i;
        res = d;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (if32.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", if32.in_ready); end
    n_cmp++; if (if32.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", if32.out_valid); end
    n_cmp++; if (if32.out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", if32.out_data); end
    n_cmp++; if (if64.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid64: got %b want 0", if64.out_valid); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++; if (if32.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", if32.in_ready); end
    n_cmp++; if (if8.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready8: got %b want 1", if8.in_ready); end
  endtask

  task automatic test_sll_latency();
    logic [63:0] r;
    int          lat;
    do_op(32, 64'h12345678, 8, MODE_SLL, r, lat);
    n_cmp++; if (r[31:0] !== 32'h34567800) begin n_err++; $display("FAIL sll8_data: got %h want 34567800", r[31:0]); end
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL sll8_latency: got %0d want 2", lat); end
  endtask

  task automatic test_sra_srl_zero();
    logic [63:0] r;
    int          lat;
    do_op(32, 64'h80000000, 31, MODE_SRA, r, lat);
    n_cmp++; if (r[31:0] !== 32'hFFFFFFFF) begin n_err++; $display("FAIL sra31: got %h want ffffffff", r[31:0]); end
    do_op(32, 64'h80000000, 31, MODE_SRL, r, lat);
    n_cmp++; if (r[31:0] !== 32'h00000001) begin n_err++; $display("FAIL srl31: got %h want 00000001", r[31:0]); end
    do_op(32, 64'h40000000, 4, MODE_SRA, r, lat);
    n_cmp++; if (r[31:0] !== 32'h04000000) begin n_err++; $display("FAIL sra_pos: got %h want 04000000", r[31:0]); end
    do_op(32, 64'h00000003, 31, MODE_SLL, r, lat);
    n_cmp++; if (r[31:0] !== 32'h80000000) begin n_err++; $display("FAIL sll31: got %h want 80000000", r[31:0]); end
    for (int m = 0; m < 4; m++) begin
      do_op(32, 64'hDEADBEEF, 0, m[1:0], r, lat);
      n_cmp++; if (r[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL shamt0_mode%0d: got %h want deadbeef", m, r[31:0]); end
    end
  endtask

  task automatic test_rotate();
    logic [63:0] r;
    int          lat;
    logic [31:0] want1, want2;
`ifdef SHIFTER_ROTATE_EN
    want1 = 32'h80000000;
    want2 = 32'h78123456;
`else
    want1 = 32'h00000000;
    want2 = 32'h00123456;
`endif
    do_op(32, 64'h00000001, 1, MODE_ROR, r, lat);
    n_cmp++; if (r[31:0] !== want1) begin n_err++; $display("FAIL mode11_a: got %h want %h", r[31:0], want1); end
    do_op(32, 64'h12345678, 8, MODE_ROR, r, lat);
    n_cmp++; if (r[31:0] !== want2) begin n_err++; $display("FAIL mode11_b: got %h want %h", r[31:0], want2); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [8] = '{32'h12345678, 32'h80000001, 32'hF0000000, 32'h00000001,
                            32'hCAFEBABE, 32'h7FFFFFFF, 32'h0000FFFF, 32'h89ABCDEF};
    int          vs [8] = '{4, 1, 4, 1, 16, 30, 0, 12};
    logic [1:0]  vm [8] = '{MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROR,
                            MODE_SLL, MODE_SRA, MODE_SRL, MODE_ROR};
    logic [31:0] exp_q [$];
    logic [31:0] held;
    logic [31:0] want;
    logic        stalled;
    logic        adv_exp;
    int          sent;
    int          got;
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clock);
      if32.out_ready = (cyc % 2 == 0);
      if (sent < 8) begin
        if32.in_valid = 1'b1; if32.in_data = va[sent]; if32.in_shamt = vs[sent][4:0]; if32.in_mode = vm[sent];
      end else begin
        if32.in_valid = 1'b0;
      end
      #1;
      if (stalled) begin
        n_cmp++; if (if32.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_hold_valid: got %b want 1", if32.out_valid); end
        n_cmp++; if (if32.out_data !== held) begin n_err++; $display("FAIL b2b_hold_data: got %h want %h", if32.out_data, held); end
      end
      adv_exp = !if32.out_valid || if32.out_ready;
      n_cmp++; if (if32.in_ready !== adv_exp) begin n_err++; $display("FAIL b2b_in_ready: got %b want %b", if32.in_ready, adv_exp); end
      if (if32.out_valid && if32.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra_beat: got %h want none", if32.out_data);
        end else begin
          want = exp_q.pop_front();
          if (if32.out_data !== want) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", got, if32.out_data, want); end
        end
        got++;
      end
      stalled = if32.out_valid && !if32.out_ready;
      held    = if32.out_data;
      if (if32.in_valid && adv_exp) begin
        exp_q.push_back(model(32, {32'd0, va[sent]}, vs[sent], vm[sent])[31:0]);
        sent++;
      end
    end
    n_cmp++; if (got !== 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", got); end
    if32.in_valid  = 1'b0;
    if32.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_cmp++; if (if32.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_dup: got %b want 0", if32.out_valid); end
    end
  endtask

  task automatic test_reset_flight();
    int stale;
    @(negedge clock);
    if32.out_ready = 1'b1;
    if32.in_valid = 1'b1; if32.in_data = 32'h11111111; if32.in_shamt = 5'd1; if32.in_mode = MODE_SLL;
    @(negedge clock);
    if32.in_data = 32'h22222222;
    @(posedge clock);
    #2;
    n_cmp++; if (if32.out_valid !== 1'b1) begin n_err++; $display("FAIL flight_pre_valid: got %b want 1", if32.out_valid); end
    reset = 1'b1;
    #1;
    n_cmp++; if (if32.out_valid !== 1'b0) begin n_err++; $display("FAIL flight_rst_valid: got %b want 0", if32.out_valid); end
    n_cmp++; if (if32.out_data !== 32'h0) begin n_err++; $display("FAIL flight_rst_data: got %h want 0", if32.out_data); end
    n_cmp++; if (if32.in_ready !== 1'b0) begin n_err++; $display("FAIL flight_rst_ready: got %b want 0", if32.in_ready); end
    if32.in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++; if (if32.in_ready !== 1'b1) begin n_err++; $display("FAIL flight_release_ready: got %b want 1", if32.in_ready); end
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (if32.out_valid !== 1'b0) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_err++; $display("FAIL flight_stale: got %0d valid cycles want 0", stale); end
  endtask

  task automatic test_sweep();
    logic [63:0] a, r, want;
    int          sh, lat, w, rk;
    logic [1:0]  m;
    for (int s = 0; s < 2; s++) begin
      w  = (s == 0) ? 8 : 64;
      rk = (s == 0) ? RANKS8 : RANKS64;
      for (int i = 0; i < 12; i++) begin
        a  = {$urandom, $urandom};
        m  = 2'($urandom_range(3, 0));
        sh = (i == 0) ? w - 1 : (i == 1) ? 0 : int'($urandom_range(w - 1, 0));
        if (i == 0) begin a[w-1] = 1'b1; m = MODE_SRA; end
        want = model(w, a, sh, m);
        do_op(w, a, sh, m, r, lat);
        n_cmp++; if (r !== want) begin n_err++; $display("FAIL sweep_w%0d_%0d: got %h want %h", w, i, r, want); end
        n_cmp++; if (lat !== rk) begin n_err++; $display("FAIL sweep_lat_w%0d_%0d: got %0d want %0d", w, i, lat, rk); end
      end
    end
  endtask

  initial begin
    drive(8,  1'b0, 64'd0, 0, MODE_SLL);
    drive(32, 1'b0, 64'd0, 0, MODE_SLL);
    drive(64, 1'b0, 64'd0, 0, MODE_SLL);
    #1 reset = 1'b1;
    test_reset();
    test_sll_latency();
    test_sra_srl_zero();
    test_rotate();
    test_back_to_back();
    test_reset_flight();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
